// File: rtl/alu_ctrl_pkg.sv
// rtl/alu_ctrl_pkg.sv - opcode and FSM state encodings shared by the ALU op sequencer
package alu_ctrl_pkg;

    localparam logic [2:0] OP_AND    = 3'b000;
    localparam logic [2:0] OP_OR     = 3'b001;
    localparam logic [2:0] OP_ADDSUB = 3'b010;
    localparam logic [2:0] OP_SLT    = 3'b011;
    localparam logic [2:0] OP_MUL    = 3'b100;
    localparam logic [2:0] OP_XOR    = 3'b101;
    localparam logic [2:0] OP_SLL    = 3'b110;
    localparam logic [2:0] OP_RSV    = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_MULW = 2'd2,
        ST_RESP = 2'd3
    } state_t;

endpackage

// File: rtl/alu_op_sequencer_if.sv
// rtl/alu_op_sequencer_if.sv - request/response channels and result-mux control of the ALU op sequencer
interface alu_op_sequencer_if #(
    parameter int W = 32
);
    logic         req_valid;
    logic         req_ready;
    logic [2:0]   req_op;
    logic [2:0]   alu_sel;
    logic         mul_start;
    logic [W-1:0] alu_result;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [W-1:0] rsp_data;
    logic [2:0]   rsp_op;
    logic         rsp_err;
    logic         busy;

    modport master (
        output req_valid, req_op, alu_result, rsp_ready,
        input  req_ready, alu_sel, mul_start, rsp_valid, rsp_data, rsp_op, rsp_err, busy
    );

    modport slave (
        input  req_valid, req_op, alu_result, rsp_ready,
        output req_ready, alu_sel, mul_start, rsp_valid, rsp_data, rsp_op, rsp_err, busy
    );
endinterface

// File: rtl/alu_lat_cnt.sv
// rtl/alu_lat_cnt.sv - 4-bit loadable down-counter with zero flag for the multiply wait
module alu_lat_cnt (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load_i,
    input  logic [3:0] load_val_i,
    input  logic       dec_i,
    output logic       zero_o
);
    logic [3:0] cnt_q;
    logic [3:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != 4'd0)) begin
            cnt_d = cnt_q - 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == 4'd0);
endmodule

// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - one-at-a-time ALU op sequencer: drives result select, times MUL, returns captured result
module alu_op_sequencer
    import alu_ctrl_pkg::*;
#(
    parameter int W       = 32,
    parameter int MUL_LAT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    alu_op_sequencer_if.slave bus
);
    localparam logic [3:0] MUL_LOAD = 4'(MUL_LAT - 1);

    state_t       state_q, state_d;
    logic [2:0]   op_q, op_d;
    logic [W-1:0] rsp_data_q, rsp_data_d;
    logic         rsp_err_q, rsp_err_d;
    logic         mul_start_q, mul_start_d;
    logic         cnt_load;
    logic         cnt_dec;
    logic         cnt_zero;

    alu_lat_cnt u_lat_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (cnt_load),
        .load_val_i (MUL_LOAD),
        .dec_i      (cnt_dec),
        .zero_o     (cnt_zero)
    );

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        mul_start_d = 1'b0;
        cnt_load    = 1'b0;
        cnt_dec     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    op_d = bus.req_op;
                    case (bus.req_op)
                        OP_RSV: begin
                            state_d    = ST_RESP;
                            rsp_err_d  = 1'b1;
                            rsp_data_d = '0;
                        end
                        OP_MUL: begin
                            state_d     = ST_MULW;
                            cnt_load    = 1'b1;
                            mul_start_d = 1'b1;
                        end
                        default: state_d = ST_EXEC;
                    endcase
                end
            end
            ST_EXEC: begin
                rsp_data_d = bus.alu_result;
                rsp_err_d  = 1'b0;
                state_d    = ST_RESP;
            end
            ST_MULW: begin
                // Counter reaching zero marks the last cycle of multiplier latency.
                if (cnt_zero) begin
                    rsp_data_d = bus.alu_result;
                    rsp_err_d  = 1'b0;
                    state_d    = ST_RESP;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            op_q        <= OP_AND;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            mul_start_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
            mul_start_q <= mul_start_d;
        end
    end

    assign bus.req_ready = (state_q == ST_IDLE);
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.rsp_valid = (state_q == ST_RESP);
    assign bus.alu_sel   = op_q;
    assign bus.rsp_op    = op_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.mul_start = mul_start_q;
endmodule

// File: doc/alu_op_sequencer.md
# alu_op_sequencer

Control sequencer for the 8-way ALU result select of the CPU datapath. It accepts one ALU operation at a time over a valid/ready request channel and drives the 3-bit result-select bus to the per-bit 8:1 result muxes. It times single-cycle and multi-cycle operations (MUL has a fixed parameterised latency), captures the selected result, and returns it on a valid/ready response channel. Reserved opcode 111 is rejected with an error response.

## Interface
- W, default 32: datapath width; width of `alu_result` and `rsp_data`.
- MUL_LAT, default 4: cycles the multiplier needs after `mul_start`; legal range 1..15.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  sequencer can accept a request.
- req_op  in  3  operation: 000 AND, 001 OR, 010 ADD/SUB, 011 SLT, 100 MUL, 101 XOR, 110 SLL, 111 reserved.
- alu_sel  out  3  select bus to the result muxes.
- mul_start  out  1  one-cycle start pulse to the multiplier.
- alu_result  in  W  assembled result-mux outputs.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_data  out  W  captured result.
- rsp_op  out  3  opcode of the response.
- rsp_err  out  1  response is for a reserved opcode.
- busy  out  1  high whenever state is not IDLE.

## Operation
- States: IDLE, EXEC, MULW, RESP.
- IDLE: `req_ready` = 1. Handshake is `req_valid & req_ready`. On handshake, latch `req_op` into the op register, which drives `alu_sel` and `rsp_op`. Next state:
  - 111 → RESP with `rsp_err` = 1 and `rsp_data` = 0.
  - 100 → MULW with the counter loaded to MUL_LAT−1.
  - any other opcode → EXEC.
- EXEC: lasts one cycle. Capture `alu_result` into `rsp_data` at the end of the cycle, clear `rsp_err`, go to RESP.
- MULW:
  - `mul_start` = 1 only in the first MULW cycle.
  - The counter decrements each cycle.
  - When the counter is 0, capture `alu_result`, clear `rsp_err`, go to RESP.
- RESP:
  - `rsp_valid` = 1; `rsp_data`, `rsp_op` and `rsp_err` are held stable.
  - On `rsp_ready`, go to IDLE.
  - `req_ready` = 0; no overlap with the next request.
- `alu_sel` holds the latched op from accept until the next accept, including through IDLE.
- `req_op` and `alu_result` are ignored outside their sampling points.
- Counter width is 4 bits.

## Timing
- Reset (async assert, sync deassert by the user): state IDLE, `alu_sel` = 000, `rsp_data` = 0, `rsp_op` = 000, `rsp_err` = 0, `rsp_valid` = 0, `mul_start` = 0, `busy` = 0, `req_ready` = 1 once out of reset.
- Non-MUL op, accepted at edge E0:
  - EXEC runs from E0 to E1; `alu_result` is sampled at E1.
  - `rsp_valid` is high from E1, so request-to-response is 1 cycle of EXEC.
- MUL op, accepted at E0:
  - `mul_start` is high from E0 to E1.
  - `alu_result` is sampled at E(MUL_LAT).
  - `rsp_valid` is high from E(MUL_LAT).
- Reserved op, accepted at E0: `rsp_valid` is high from E0, with no EXEC cycle.
- Back-pressure: `rsp_valid` stays high until `rsp_ready`. The earliest next accept is the edge after the `rsp_ready` handshake.
- Minimum throughput: one non-MUL op per 3 cycles when `rsp_ready` is tied high.
- `rst_n` asserted mid-operation: immediate return to reset values; the pending response is discarded and `mul_start` is dropped.
- `req_valid` while busy: ignored; the requester must hold it until `req_ready`.

## Structure
- Shared package `alu_ctrl_pkg` contains:
  - opcode constants OP_AND, OP_OR, OP_ADDSUB, OP_SLT, OP_MUL, OP_XOR, OP_SLL, OP_RSV (000..111);
  - state encoding constants ST_IDLE, ST_EXEC, ST_MULW, ST_RESP.
- One sub-module `alu_lat_cnt`: a 4-bit loadable down-counter with a `zero` flag. It is instantiated once for the MULW wait.
- The top level contains the FSM, the op register, and the response registers.

## Test plan
- Reset: hold `rst_n` = 0 for 3 cycles → all outputs at their reset values, `req_ready` = 1 after release.
- Single ops: XOR (101) with `alu_result` = 32'h0000_00F0 at the sample edge, `rsp_ready` = 1 → `alu_sel` = 101, `rsp_valid` one cycle after accept, `rsp_data` = 32'h0000_00F0, `rsp_op` = 101, `rsp_err` = 0. Repeat for opcodes 000, 001, 010, 011, 110.
- MUL with MUL_LAT = 4: accept op 100 → `mul_start` high for exactly one cycle. Drive `alu_result` to 32'hDEAD_BEEF only at edge E4 → `rsp_valid` at E4 with `rsp_data` = 32'hDEAD_BEEF. Values driven at E1..E3 are not captured.
- Reserved op 111 → `rsp_valid` on the cycle after accept, `rsp_err` = 1, `rsp_data` = 0, no `mul_start`.
- Back-pressure: hold `rsp_ready` = 0 for 5 cycles while a new `req_valid` is asserted → response stable, `req_ready` = 0, new request accepted only on the cycle after `rsp_ready` = 1.
- Reset mid-MUL: assert `rst_n` = 0 during the 2nd MULW cycle → outputs return to reset values at once, no `rsp_valid`, a new ADD completes normally after release.
